lsu_sequencer: RTL and testbench

- Sequences load/store requests from the execute stage onto a single-port, word-wide data memory.
- Generates the byte-lane write mask and lane-aligned store data, and formats load data with sign or zero extension.
- Splits accesses that cross a word boundary into two word transactions and merges the results.
- Sits between the core's memory stage and the data memory bus. Exactly one request is in flight at a time.

---
 rtl/lsu_sequencer_pkg.sv | 37 +++
 rtl/lsu_sequencer_if.sv | 37 +++
 rtl/lsu_sequencer_load_format.sv | 29 ++
 rtl/lsu_sequencer.sv | 178 +++++++++++++++++
 tb/tb_lsu_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_sequencer_pkg.sv
// lsu_pkg: shared definitions for the load/store sequencer.
// Holds the funct3 access-size codes, the sequencer FSM state type and
// small decode helpers used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC0 = 2'd1,
    S_ACC1 = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  // Access size in bytes from funct3[1:0]; 11 only occurs on illegal requests.
  function automatic logic [2:0] size_decode(input logic [2:0] fun3);
    case (fun3[1:0])
      2'b00:   size_decode = 3'd1;
      2'b01:   size_decode = 3'd2;
      default: size_decode = 3'd4;
    endcase
  endfunction

  // Stores have no unsigned variants; loads accept lwu as a plain word.
  function automatic logic f3_legal(input logic store, input logic [2:0] fun3);
    if (store)
      f3_legal = (fun3 == F3_B) || (fun3 == F3_H) || (fun3 == F3_W);
    else
      f3_legal = (fun3 != 3'b011) && (fun3 != 3'b111);
  endfunction

endpackage

// File: rtl/lsu_sequencer_if.sv
// lsu_sequencer_if: core request/response and data memory bus bundle.
// Ports: req_* (core -> sequencer, valid/ready), rsp_* (one-cycle strobe),
// mem_* (single-port word memory, ack completes a transaction).
interface lsu_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_fun3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  // Sequencer side.
  modport slave (
    input  req_valid, req_store, req_fun3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata
  );

  // Environment side (core plus memory).
  modport master (
    output req_valid, req_store, req_fun3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/lsu_sequencer_load_format.sv
// lsu_load_format: extracts a load result from a two-word read buffer.
// Ports: buf_i (word1:word0), off_i (byte offset), fun3_i (size/sign) -> rdata_o.
// Purely combinational; no latency, no backpressure.
module lsu_load_format
  import lsu_pkg::*;
(
  input  logic [63:0] buf_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  fun3_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // Offset at most 3 bytes, so the low 32 bits of the shifted buffer
  // always hold the whole access.
  assign shifted = 32'(buf_i >> {off_i, 3'b000});

  always_comb begin
    case (fun3_i[1:0])
      2'b00:   rdata_o = fun3_i[2] ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   rdata_o = fun3_i[2] ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// lsu_sequencer: sequences one load/store at a time onto a word-wide memory,
// splitting word-crossing accesses into two beats when SPLIT_EN=1.
// Latency: accept T, mem_req T+1, rsp_valid T+2 (single) / T+3 (split), +1 per wait.
// Backpressure: req_ready only in IDLE; each beat holds until mem_ack.
// Ports: clk, rst_n (async active-low), bus (lsu_sequencer_if.slave).
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  lsu_sequencer_if.slave  bus
);

  lsu_state_e        state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        fun3_q, fun3_d;
  logic [1:0]        off_q, off_d;
  logic              split_q, split_d;
  logic              err_q, err_d;
  logic [3:0]        mask_hi_q, mask_hi_d;
  logic [31:0]       wdata_hi_q, wdata_hi_d;
  logic [63:0]       buf_q, buf_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  // Decode of the request presented in IDLE.
  logic [2:0]  acc_size;
  logic [1:0]  acc_off;
  logic        acc_split;
  logic        acc_err;
  logic [3:0]  acc_ones;
  logic [7:0]  acc_mask8;
  logic [63:0] acc_data64;
  logic [31:0] fmt_rdata;

  assign acc_size   = size_decode(bus.req_fun3);
  assign acc_off    = bus.req_addr[1:0];
  assign acc_split  = ({2'b00, acc_off} + {1'b0, acc_size}) > 4'd4;
  assign acc_err    = !f3_legal(bus.req_store, bus.req_fun3) || (acc_split && !SPLIT_EN);
  assign acc_ones   = (acc_size == 3'd1) ? 4'b0001 :
                      (acc_size == 3'd2) ? 4'b0011 : 4'b1111;
  // Low halves feed beat 0, high halves feed beat 1 of a split store.
  assign acc_mask8  = {4'b0000, acc_ones} << acc_off;
  assign acc_data64 = {32'h0, bus.req_wdata} << {acc_off, 3'b000};

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    fun3_d      = fun3_q;
    off_d       = off_q;
    split_d     = split_q;
    err_d       = err_q;
    mask_hi_d   = mask_hi_q;
    wdata_hi_d  = wdata_hi_q;
    buf_d       = buf_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          store_d    = bus.req_store;
          fun3_d     = bus.req_fun3;
          off_d      = acc_off;
          split_d    = acc_split;
          err_d      = acc_err;
          mask_hi_d  = bus.req_store ? acc_mask8[7:4] : 4'h0;
          wdata_hi_d = bus.req_store ? acc_data64[63:32] : 32'h0;
          buf_d      = 64'h0;
          if (acc_err) begin
            state_d = S_RESP;
          end else begin
            state_d     = S_ACC0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_store;
            mem_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
            mem_wmask_d = bus.req_store ? acc_mask8[3:0] : 4'h0;
            mem_wdata_d = bus.req_store ? acc_data64[31:0] : 32'h0;
          end
        end
      end
      S_ACC0: begin
        if (bus.mem_ack) begin
          buf_d[31:0] = bus.mem_rdata;
          if (split_q) begin
            // Second beat: next word, wrapping at the top of the address space.
            state_d     = S_ACC1;
            mem_addr_d  = mem_addr_q + ADDR_W'(4);
            mem_wmask_d = mask_hi_q;
            mem_wdata_d = wdata_hi_q;
          end else begin
            state_d     = S_RESP;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wmask_d = 4'h0;
            mem_wdata_d = 32'h0;
          end
        end
      end
      S_ACC1: begin
        if (bus.mem_ack) begin
          buf_d[63:32] = bus.mem_rdata;
          state_d      = S_RESP;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = '0;
          mem_wmask_d  = 4'h0;
          mem_wdata_d  = 32'h0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      fun3_q      <= 3'b000;
      off_q       <= 2'b00;
      split_q     <= 1'b0;
      err_q       <= 1'b0;
      mask_hi_q   <= 4'h0;
      wdata_hi_q  <= 32'h0;
      buf_q       <= 64'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wmask_q <= 4'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      fun3_q      <= fun3_d;
      off_q       <= off_d;
      split_q     <= split_d;
      err_q       <= err_d;
      mask_hi_q   <= mask_hi_d;
      wdata_hi_q  <= wdata_hi_d;
      buf_q       <= buf_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  lsu_load_format u_fmt (
    .buf_i   (buf_q),
    .off_i   (off_q),
    .fun3_i  (fun3_q),
    .rdata_o (fmt_rdata)
  );

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_err   = (state_q == S_RESP) && err_q;
  // Stores and errored requests report zero data.
  assign bus.rsp_rdata = ((state_q == S_RESP) && !err_q && !store_q) ? fmt_rdata : 32'h0;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// tb_lsu_sequencer: directed bench for lsu_sequencer with a byte-level model.
// Two instances: u_split (SPLIT_EN=1) and u_nosplit (SPLIT_EN=0), selected by sel.
module tb_lsu_sequencer;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_store;
  logic [2:0]  req_fun3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_sequencer_if #(.ADDR_W(32)) bus_s ();
  lsu_sequencer_if #(.ADDR_W(32)) bus_n ();

  assign bus_s.req_valid = req_valid & sel;
  assign bus_n.req_valid = req_valid & ~sel;
  assign bus_s.mem_ack   = mem_ack & sel;
  assign bus_n.mem_ack   = mem_ack & ~sel;
  assign bus_s.req_store = req_store;
  assign bus_n.req_store = req_store;
  assign bus_s.req_fun3  = req_fun3;
  assign bus_n.req_fun3  = req_fun3;
  assign bus_s.req_addr  = req_addr;
  assign bus_n.req_addr  = req_addr;
  assign bus_s.req_wdata = req_wdata;
  assign bus_n.req_wdata = req_wdata;
  assign bus_s.mem_rdata = mem_rdata;
  assign bus_n.mem_rdata = mem_rdata;

  lsu_sequencer #(.ADDR_W(32), .SPLIT_EN(1'b1)) u_split (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  lsu_sequencer #(.ADDR_W(32), .SPLIT_EN(1'b0)) u_nosplit (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_n)
  );

  // Observed outputs of the selected instance.
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_mem_req, o_mem_we;
  logic [31:0] o_rsp_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wmask;

  always_comb begin
    o_req_ready = sel ? bus_s.req_ready : bus_n.req_ready;
    o_rsp_valid = sel ? bus_s.rsp_valid : bus_n.rsp_valid;
    o_rsp_err   = sel ? bus_s.rsp_err   : bus_n.rsp_err;
    o_rsp_rdata = sel ? bus_s.rsp_rdata : bus_n.rsp_rdata;
    o_mem_req   = sel ? bus_s.mem_req   : bus_n.mem_req;
    o_mem_we    = sel ? bus_s.mem_we    : bus_n.mem_we;
    o_mem_addr  = sel ? bus_s.mem_addr  : bus_n.mem_addr;
    o_mem_wmask = sel ? bus_s.mem_wmask : bus_n.mem_wmask;
    o_mem_wdata = sel ? bus_s.mem_wdata : bus_n.mem_wdata;
  end

  // Model expectations for the current transaction.
  logic [31:0] e_addr [2];
  logic [31:0] e_data [2];
  logic [3:0]  e_mask [2];
  logic        e_we;
  int          e_nb;
  logic [31:0] e_rdata;
  logic        e_err;
  int          e_lat;

  // Captures used by the literal checks.
  logic [31:0] o_beat_addr [2];
  logic [31:0] o_beat_data [2];
  logic [3:0]  o_beat_mask [2];
  logic [31:0] o_rdata;
  int          o_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Byte-lane view: request byte i lives at lane (offset+i) of the word pair.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] w0, input logic [31:0] w1,
                       input logic split_en, input int wt);
    int size;
    int off;
    int lane;
    logic legal;
    logic split;
    logic [63:0] words;
    legal = st ? (f3 <= 3'd2) : ((f3 != 3'd3) && (f3 != 3'd7));
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off   = int'(a[1:0]);
    split = (off + size) > 4;
    e_err = !legal || (split && !split_en);
    e_nb  = e_err ? 0 : (split ? 2 : 1);
    e_we  = st;
    for (int b = 0; b < 2; b++) begin
      e_addr[b] = {a[31:2], 2'b00} + 32'(4 * b);
      e_mask[b] = 4'h0;
      e_data[b] = 32'h0;
    end
    if (!e_err && st) begin
      for (int i = 0; i < 4; i++) begin
        lane = off + i;
        if (i < size) e_mask[lane / 4][lane % 4] = 1'b1;
        e_data[lane / 4][8 * (lane % 4) +: 8] = wd[8 * i +: 8];
      end
    end
    e_rdata = 32'h0;
    if (!e_err && !st) begin
      words = {w1, w0};
      for (int j = 0; j < size; j++) begin
        lane = off + j;
        e_rdata[8 * j +: 8] = words[8 * lane +: 8];
      end
      if (!f3[2] && size < 4 && e_rdata[8 * size - 1]) e_rdata = e_rdata | (32'hFFFF_FFFF << (8 * size));
    end
    e_lat = e_err ? 1 : 1 + e_nb * (wt + 1);
  endtask

  // Issue one request, act as the memory, check every cycle until rsp_valid.
  task automatic run(input string nm, input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] w0, input logic [31:0] w1,
                     input int wt, input logic stray);
    int bi;
    int waited;
    logic done;
    model(st, f3, a, wd, w0, w1, sel, wt);
    o_beat_addr[0] = 32'h0; o_beat_addr[1] = 32'h0;
    o_beat_data[0] = 32'h0; o_beat_data[1] = 32'h0;
    o_beat_mask[0] = 4'h0;  o_beat_mask[1] = 4'h0;
    o_lat = 0;
    @(negedge clk);
    chk({nm, ".ready_idle"}, 32'(o_req_ready), 32'd1);
    chk({nm, ".rsp_idle"}, 32'(o_rsp_valid), 32'd0);
    req_valid = 1'b1;
    req_store = st;
    req_fun3  = f3;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    bi = 0;
    waited = 0;
    done = 1'b0;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      chk({nm, ".ready_busy"}, 32'(o_req_ready), 32'd0);
      if (o_mem_req) begin
        if (bi >= e_nb) begin
          total++;
          bad++;
          $display("FAIL %s.extra_beat got=beat%0d exp=%0d beats", nm, bi, e_nb);
          mem_ack = 1'b0;
        end else begin
          chk({nm, ".addr"}, o_mem_addr, e_addr[bi]);
          chk({nm, ".we"}, 32'(o_mem_we), 32'(e_we));
          chk({nm, ".wmask"}, 32'(o_mem_wmask), 32'(e_mask[bi]));
          chk({nm, ".wdata"}, o_mem_wdata, e_data[bi]);
          o_beat_addr[bi] = o_mem_addr;
          o_beat_data[bi] = o_mem_wdata;
          o_beat_mask[bi] = o_mem_wmask;
          if (waited == wt) begin
            mem_ack   = 1'b1;
            mem_rdata = (bi == 0) ? w0 : w1;
            bi++;
            waited = 0;
          end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            waited++;
          end
        end
      end else begin
        mem_ack   = stray;
        mem_rdata = $urandom;
        chk({nm, ".idle_bus"}, o_mem_addr | o_mem_wdata | {27'h0, o_mem_we, o_mem_wmask}, 32'h0);
      end
      if (o_rsp_valid) begin
        done  = 1'b1;
        o_lat = cyc;
        o_rdata = o_rsp_rdata;
        chk({nm, ".rdata"}, o_rsp_rdata, e_rdata);
        chk({nm, ".err"}, 32'(o_rsp_err), 32'(e_err));
        chk({nm, ".latency"}, cyc, e_lat);
        chk({nm, ".beats"}, bi, e_nb);
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s.timeout got=no rsp_valid exp=rsp_valid within 60 cycles", nm);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    sel = 1'b1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_fun3 = 3'b000;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;

    // Reset state.
    #12;
    chk("reset.req_ready", 32'(o_req_ready), 32'd1);
    chk("reset.rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset.rsp_err", 32'(o_rsp_err), 32'd0);
    chk("reset.rsp_rdata", o_rsp_rdata, 32'h0);
    chk("reset.mem_req", 32'(o_mem_req), 32'd0);
    chk("reset.mem_bus", o_mem_addr | o_mem_wdata | {27'h0, o_mem_we, o_mem_wmask}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // sb 0x103.
    run("sb", 1'b1, F3_B, 32'h0000_0103, 32'h0000_00AB, 32'h0, 32'h0, 0, 1'b0);
    chk("sb.lit_addr", o_beat_addr[0], 32'h0000_0100);
    chk("sb.lit_mask", 32'(o_beat_mask[0]), 32'h8);
    chk("sb.lit_data_top", {24'h0, o_beat_data[0][31:24]}, 32'hAB);
    chk("sb.lit_lat", o_lat, 2);

    // lh / lhu at 0x102.
    run("lh", 1'b0, F3_H, 32'h0000_0102, 32'h0, 32'h8001_0000, 32'h0, 0, 1'b0);
    chk("lh.lit", o_rdata, 32'hFFFF_8001);
    run("lhu", 1'b0, F3_HU, 32'h0000_0102, 32'h0, 32'h8001_0000, 32'h0, 0, 1'b0);
    chk("lhu.lit", o_rdata, 32'h0000_8001);

    // Split lw at 0x201.
    run("lw_split", 1'b0, F3_W, 32'h0000_0201, 32'h0, 32'h4433_2211, 32'h8877_6655, 0, 1'b0);
    chk("lw_split.lit", o_rdata, 32'h5544_3322);
    chk("lw_split.lit_a0", o_beat_addr[0], 32'h0000_0200);
    chk("lw_split.lit_a1", o_beat_addr[1], 32'h0000_0204);
    chk("lw_split.lit_lat", o_lat, 3);

    // Split sh at 0x303.
    run("sh_split", 1'b1, F3_H, 32'h0000_0303, 32'h0000_BEEF, 32'h0, 32'h0, 0, 1'b0);
    chk("sh_split.lit_m0", 32'(o_beat_mask[0]), 32'h8);
    chk("sh_split.lit_m1", 32'(o_beat_mask[1]), 32'h1);
    chk("sh_split.lit_b0", {24'h0, o_beat_data[0][31:24]}, 32'hEF);
    chk("sh_split.lit_b1", {24'h0, o_beat_data[1][7:0]}, 32'hBE);

    // Illegal funct3, with stray acks during the response.
    run("ld_f3_011", 1'b0, 3'b011, 32'h0000_0040, 32'h0, 32'h0, 32'h0, 0, 1'b1);
    run("st_f3_100", 1'b1, 3'b100, 32'h0000_0044, 32'h1234_5678, 32'h0, 32'h0, 0, 1'b0);

    // Wait states, byte loads with sign/zero extension.
    run("lb_wait", 1'b0, F3_B, 32'h0000_0101, 32'h0, 32'h0000_F000, 32'h0, 2, 1'b0);
    chk("lb_wait.lit", o_rdata, 32'hFFFF_FFF0);
    chk("lb_wait.lit_lat", o_lat, 4);
    run("lbu", 1'b0, F3_BU, 32'h0000_0101, 32'h0, 32'h0000_F000, 32'h0, 0, 1'b0);
    chk("lbu.lit", o_rdata, 32'h0000_00F0);
    run("sw", 1'b1, F3_W, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0, 32'h0, 1, 1'b0);
    run("lwu", 1'b0, F3_WU, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
    run("sh_split_wait", 1'b1, F3_H, 32'h0000_0107, 32'hFFFF_1357, 32'h0, 32'h0, 1, 1'b0);

    // Acks while idle are ignored.
    @(negedge clk);
    mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray.mem_req", 32'(o_mem_req), 32'd0);
      chk("stray.rsp_valid", 32'(o_rsp_valid), 32'd0);
      chk("stray.req_ready", 32'(o_req_ready), 32'd1);
    end
    mem_ack = 1'b0;

    // Wrap-around split word load.
    run("lw_wrap", 1'b0, F3_W, 32'hFFFF_FFFE, 32'h0, 32'h1122_3344, 32'h5566_7788, 0, 1'b0);
    chk("lw_wrap.lit", o_rdata, 32'h7788_1122);
    chk("lw_wrap.lit_a0", o_beat_addr[0], 32'hFFFF_FFFC);
    chk("lw_wrap.lit_a1", o_beat_addr[1], 32'h0000_0000);

    // SPLIT_EN=0 instance.
    @(negedge clk);
    sel = 1'b0;
    run("ns_sw_mis", 1'b1, F3_W, 32'h0000_0002, 32'h0BAD_F00D, 32'h0, 32'h0, 0, 1'b0);
    chk("ns_sw_mis.lit_lat", o_lat, 1);
    run("ns_lh_mis", 1'b0, F3_H, 32'h0000_0003, 32'h0, 32'h0, 32'h0, 0, 1'b0);
    run("ns_lw", 1'b0, F3_W, 32'h0000_0010, 32'h0, 32'h0102_0304, 32'h0, 0, 1'b0);
    run("ns_lh_ok", 1'b0, F3_H, 32'h0000_0012, 32'h0, 32'hF00F_0000, 32'h0, 0, 1'b0);
    @(negedge clk);
    sel = 1'b1;

    // Reset in the middle of a stalled access.
    @(negedge clk);
    req_valid = 1'b1;
    req_store = 1'b0;
    req_fun3  = F3_W;
    req_addr  = 32'h0000_0500;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      chk("rst.hold_req", 32'(o_mem_req), 32'd1);
      chk("rst.hold_addr", o_mem_addr, 32'h0000_0500);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst.mem_req_drop", 32'(o_mem_req), 32'd0);
    chk("rst.req_ready", 32'(o_req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst.mem_bus", o_mem_addr | o_mem_wdata | {27'h0, o_mem_we, o_mem_wmask}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run("after_rst", 1'b0, F3_H, 32'h0000_0506, 32'h0, 32'h7FFF_0000, 32'h0, 0, 1'b0);
    chk("after_rst.lit", o_rdata, 32'h0000_7FFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
